// File: rtl/fm_spy_capture.sv
// Multi-channel circular spy buffer for the fast-monitoring path.
// Captures all channels on a shared write pointer, freezes after a trigger, and replays or fills the window.
module fm_spy_capture #(
    parameter int unsigned CH_N = 4,
    parameter int unsigned DW   = 64,
    parameter int unsigned AW   = 8
) (
    input  logic                    clk_hs,
    input  logic                    rst_hs,
    input  logic [CH_N*DW-1:0]      mon_data,
    input  logic [CH_N-1:0]         mon_vld,
    output logic [CH_N*DW-1:0]      out_data,
    output logic [CH_N-1:0]         out_vld,
    input  logic [1:0]              mode,
    input  logic                    arm,
    input  logic                    trig,
    input  logic [AW-1:0]           post_cnt,
    input  logic [DW-1:0]           init_pattern,
    output logic                    frozen,
    output logic                    init_busy,
    output logic [AW-1:0]           wr_ptr,
    output logic [AW-1:0]           trig_addr,
    input  logic                    spy_en,
    input  logic [$clog2(CH_N)-1:0] spy_ch,
    input  logic [AW-1:0]           spy_addr,
    output logic [DW-1:0]           spy_data,
    output logic                    spy_vld
);

    localparam int unsigned CW    = $clog2(CH_N);
    localparam int unsigned DEPTH = 2 ** AW;

    localparam logic [1:0] MODE_CAP  = 2'b00;
    localparam logic [1:0] MODE_ONCE = 2'b01;
    localparam logic [1:0] MODE_LOOP = 2'b10;
    localparam logic [1:0] MODE_INIT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_POST,
        ST_FROZEN,
        ST_PLAY,
        ST_INIT
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       trig_addr_q, trig_addr_d;
    logic [AW-1:0]       post_q, post_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]       play_cnt_q, play_cnt_d;
    logic                once_done_q, once_done_d;
    logic                frozen_q;
    logic                init_busy_q;
    logic [CH_N*DW-1:0]  rd_data_q;
    logic [CH_N-1:0]     rd_vld_q;
    logic                rd_pv_q;
    logic [CH_N*DW-1:0]  out_data_q;
    logic [CH_N-1:0]     out_vld_q;
    logic [DW-1:0]       spy_data_q;
    logic                spy_vld_q;

    logic                mem_we;
    logic                mem_init;
    logic                rd_en;
    logic                play_abort;
    logic [DW-1:0]       spy_word;

    logic [DW:0]         mem_q [CH_N][DEPTH];

    // Next-state and write/read control
    always_comb begin : fsm_next
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        trig_addr_d = trig_addr_q;
        post_d      = post_q;
        rd_ptr_d    = rd_ptr_q;
        play_cnt_d  = play_cnt_q;
        once_done_d = once_done_q;
        mem_we      = 1'b0;
        mem_init    = 1'b0;
        rd_en       = 1'b0;
        play_abort  = 1'b0;

        // A finished single playback is not restarted until mode leaves 01.
        if (mode != MODE_ONCE) begin
            once_done_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (mode == MODE_INIT) begin
                    state_d  = ST_INIT;
                    wr_ptr_d = '0;
                end else begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    if (arm) begin
                        state_d = ST_ARMED;
                    end
                end
            end
            ST_ARMED: begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (trig) begin
                    trig_addr_d = wr_ptr_q;
                    post_d      = post_cnt;
                    state_d     = (post_cnt == '0) ? ST_FROZEN : ST_POST;
                end
            end
            ST_POST: begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
                post_d   = post_q - AW'(1);
                if (post_q == AW'(1)) begin
                    state_d = ST_FROZEN;
                end
            end
            ST_FROZEN: begin
                if (mode == MODE_INIT) begin
                    state_d  = ST_INIT;
                    wr_ptr_d = '0;
                end else if (arm) begin
                    state_d = ST_ARMED;
                end else if ((mode == MODE_LOOP) || ((mode == MODE_ONCE) && !once_done_q)) begin
                    state_d    = ST_PLAY;
                    rd_ptr_d   = wr_ptr_q;
                    play_cnt_d = '0;
                end
            end
            ST_PLAY: begin
                if (mode == MODE_CAP) begin
                    play_abort = 1'b1;
                    state_d    = ST_FROZEN;
                end else begin
                    rd_en      = 1'b1;
                    rd_ptr_d   = rd_ptr_q + AW'(1);
                    play_cnt_d = play_cnt_q + AW'(1);
                    if ((play_cnt_q == '1) && (mode != MODE_LOOP)) begin
                        state_d     = ST_FROZEN;
                        once_done_d = (mode == MODE_ONCE);
                    end
                end
            end
            ST_INIT: begin
                mem_we   = 1'b1;
                mem_init = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (wr_ptr_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Capture memory: one shared write address, contents deliberately not reset
    always_ff @(posedge clk_hs) begin : mem_write
        if (mem_we) begin
            for (int c = 0; c < CH_N; c++) begin
                mem_q[c][wr_ptr_q] <= mem_init ? {1'b0, init_pattern}
                                               : {mon_vld[c], mon_data[c*DW +: DW]};
            end
        end
    end

    // Spy channel select; unused channel codes read as zero
    always_comb begin : spy_mux
        spy_word = '0;
        for (int c = 0; c < CH_N; c++) begin
            if (spy_ch == CW'(c)) begin
                spy_word = mem_q[c][spy_addr][DW-1:0];
            end
        end
    end

    // Control state, playback read stage and status flags
    always_ff @(posedge clk_hs or posedge rst_hs) begin : ctrl_regs
        if (rst_hs) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            trig_addr_q <= '0;
            post_q      <= '0;
            rd_ptr_q    <= '0;
            play_cnt_q  <= '0;
            once_done_q <= 1'b0;
            frozen_q    <= 1'b0;
            init_busy_q <= 1'b0;
            rd_data_q   <= '0;
            rd_vld_q    <= '0;
            rd_pv_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            trig_addr_q <= trig_addr_d;
            post_q      <= post_d;
            rd_ptr_q    <= rd_ptr_d;
            play_cnt_q  <= play_cnt_d;
            once_done_q <= once_done_d;
            frozen_q    <= (state_d == ST_FROZEN) || (state_d == ST_PLAY);
            init_busy_q <= (state_d == ST_INIT);
            rd_pv_q     <= rd_en;
            if (rd_en) begin
                for (int c = 0; c < CH_N; c++) begin
                    rd_vld_q[c]            <= mem_q[c][rd_ptr_q][DW];
                    rd_data_q[c*DW +: DW]  <= mem_q[c][rd_ptr_q][DW-1:0];
                end
            end
        end
    end

    // Output stage: playback words drain even after the FSM has left PLAY
    always_ff @(posedge clk_hs or posedge rst_hs) begin : out_regs
        if (rst_hs) begin
            out_data_q <= '0;
            out_vld_q  <= '0;
        end else if (play_abort || (state_d == ST_INIT)) begin
            out_data_q <= '0;
            out_vld_q  <= '0;
        end else if (rd_pv_q) begin
            out_data_q <= rd_data_q;
            out_vld_q  <= rd_vld_q;
        end else if (state_q == ST_PLAY) begin
            out_data_q <= '0;
            out_vld_q  <= '0;
        end else begin
            out_data_q <= mon_data;
            out_vld_q  <= mon_vld;
        end
    end

    // Spy read register, read-first against a same-cycle write
    always_ff @(posedge clk_hs or posedge rst_hs) begin : spy_regs
        if (rst_hs) begin
            spy_data_q <= '0;
            spy_vld_q  <= 1'b0;
        end else if (spy_en) begin
            spy_data_q <= spy_word;
            spy_vld_q  <= 1'b1;
        end else begin
            spy_data_q <= '0;
            spy_vld_q  <= 1'b0;
        end
    end

    assign out_data  = out_data_q;
    assign out_vld   = out_vld_q;
    assign frozen    = frozen_q;
    assign init_busy = init_busy_q;
    assign wr_ptr    = wr_ptr_q;
    assign trig_addr = trig_addr_q;
    assign spy_data  = spy_data_q;
    assign spy_vld   = spy_vld_q;

endmodule

// File: tb/tb_fm_spy_capture.sv
// Directed bench for fm_spy_capture with CH_N=2, DW=8, AW=4.
module tb_fm_spy_capture;

    localparam int unsigned CH_N = 2;
    localparam int unsigned DW   = 8;
    localparam int unsigned AW   = 4;

    logic        clk_hs = 1'b0;
    logic        rst_hs;
    logic [15:0] mon_data;
    logic [1:0]  mon_vld;
    logic [15:0] out_data;
    logic [1:0]  out_vld;
    logic [1:0]  mode;
    logic        arm;
    logic        trig;
    logic [3:0]  post_cnt;
    logic [7:0]  init_pattern;
    logic        frozen;
    logic        init_busy;
    logic [3:0]  wr_ptr;
    logic [3:0]  trig_addr;
    logic        spy_en;
    logic        spy_ch;
    logic [3:0]  spy_addr;
    logic [7:0]  spy_data;
    logic        spy_vld;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [3:0]  exp_wp;

    always #5 clk_hs = ~clk_hs;

    fm_spy_capture #(.CH_N(CH_N), .DW(DW), .AW(AW)) dut (
        .clk_hs       (clk_hs),
        .rst_hs       (rst_hs),
        .mon_data     (mon_data),
        .mon_vld      (mon_vld),
        .out_data     (out_data),
        .out_vld      (out_vld),
        .mode         (mode),
        .arm          (arm),
        .trig         (trig),
        .post_cnt     (post_cnt),
        .init_pattern (init_pattern),
        .frozen       (frozen),
        .init_busy    (init_busy),
        .wr_ptr       (wr_ptr),
        .trig_addr    (trig_addr),
        .spy_en       (spy_en),
        .spy_ch       (spy_ch),
        .spy_addr     (spy_addr),
        .spy_data     (spy_data),
        .spy_vld      (spy_vld)
    );

    function automatic logic [15:0] gen_data(input logic [3:0] a);
        logic [7:0] a8;
        a8 = {4'h0, a};
        return {8'hC0 + a8, 8'h40 + a8};
    endfunction

    function automatic logic [1:0] gen_vld(input logic [3:0] a);
        return {~a[0], a[0]};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk_hs);
        #1;
    endtask

    task automatic drive_gen();
        mon_data = gen_data(exp_wp);
        mon_vld  = gen_vld(exp_wp);
        exp_wp   = exp_wp + 4'd1;
    endtask

    task automatic test_reset();
        rst_hs = 1'b1; mode = 2'b00; arm = 1'b0; trig = 1'b0; post_cnt = 4'd0;
        init_pattern = 8'h00; spy_en = 1'b0; spy_ch = 1'b0; spy_addr = 4'd0;
        mon_data = 16'h0011; mon_vld = 2'b01;
        step(3);
        n_tests++;
        if ({out_data, out_vld, frozen, init_busy, wr_ptr, trig_addr, spy_data, spy_vld} !== 40'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got out=%h vld=%b frz=%b busy=%b wp=%0d ta=%0d spy=%h/%b want all 0",
                     out_data, out_vld, frozen, init_busy, wr_ptr, trig_addr, spy_data, spy_vld);
        end
        rst_hs = 1'b0;
        step(1);
        exp_wp = 4'd1;
        n_tests++;
        if ({out_vld, out_data} !== {2'b01, 16'h0011}) begin
            n_fail++;
            $display("FAIL passthrough: got vld=%b data=%h want vld=01 data=0011", out_vld, out_data);
        end
        n_tests++;
        if (wr_ptr !== 4'd1) begin
            n_fail++;
            $display("FAIL first_write_ptr: got %0d want 1", wr_ptr);
        end
    endtask

    task automatic test_trigger();
        for (int i = 0; i < 19; i++) begin
            drive_gen();
            step(1);
        end
        arm = 1'b1;
        drive_gen();
        step(1);
        arm = 1'b0;
        n_tests++;
        if (wr_ptr !== 4'd5 || out_data !== gen_data(4'd4)) begin
            n_fail++;
            $display("FAIL armed_ptr: got wp=%0d out=%h want wp=5 out=%h", wr_ptr, out_data, gen_data(4'd4));
        end
        trig = 1'b1; post_cnt = 4'd3;
        drive_gen();
        step(1);
        trig = 1'b0;
        n_tests++;
        if (trig_addr !== 4'd5 || frozen !== 1'b0) begin
            n_fail++;
            $display("FAIL trig_taken: got ta=%0d frz=%b want ta=5 frz=0", trig_addr, frozen);
        end
        post_cnt = 4'd9;
        trig = 1'b1;
        drive_gen();
        step(1);
        trig = 1'b0;
        n_tests++;
        if (trig_addr !== 4'd5) begin
            n_fail++;
            $display("FAIL trig_in_post: got ta=%0d want 5", trig_addr);
        end
        drive_gen();
        step(1);
        n_tests++;
        if (frozen !== 1'b0) begin
            n_fail++;
            $display("FAIL post_early_freeze: got frz=%b want 0", frozen);
        end
        drive_gen();
        step(1);
        n_tests++;
        if (frozen !== 1'b1 || wr_ptr !== 4'd9) begin
            n_fail++;
            $display("FAIL freeze: got frz=%b wp=%0d want frz=1 wp=9", frozen, wr_ptr);
        end
        mon_data = 16'hEEEE; mon_vld = 2'b11;
        step(3);
        n_tests++;
        if (wr_ptr !== 4'd9) begin
            n_fail++;
            $display("FAIL frozen_hold: got wp=%0d want 9", wr_ptr);
        end
        spy_en = 1'b1; spy_ch = 1'b0; spy_addr = 4'd9;
        step(1);
        n_tests++;
        if (spy_vld !== 1'b1 || spy_data !== 8'h49) begin
            n_fail++;
            $display("FAIL spy_frozen_a9: got %b/%h want 1/49", spy_vld, spy_data);
        end
        spy_ch = 1'b1; spy_addr = 4'd5;
        step(1);
        n_tests++;
        if (spy_vld !== 1'b1 || spy_data !== 8'hC5) begin
            n_fail++;
            $display("FAIL spy_trig_word: got %b/%h want 1/c5", spy_vld, spy_data);
        end
        spy_en = 1'b0;
        step(1);
        n_tests++;
        if (spy_vld !== 1'b0 || spy_data !== 8'h00) begin
            n_fail++;
            $display("FAIL spy_idle_zero: got %b/%h want 0/00", spy_vld, spy_data);
        end
    endtask

    task automatic test_play_once();
        logic [3:0] a;
        mon_data = 16'h0000; mon_vld = 2'b00; mode = 2'b01;
        step(2);
        n_tests++;
        if (out_vld !== 2'b00) begin
            n_fail++;
            $display("FAIL once_lead_gap: got vld=%b want 00", out_vld);
        end
        for (int k = 0; k < 16; k++) begin
            step(1);
            a = 4'(9 + k);
            n_tests++;
            if ({out_vld, out_data} !== {gen_vld(a), gen_data(a)} || frozen !== 1'b1) begin
                n_fail++;
                $display("FAIL once_word[%0d]: got vld=%b data=%h frz=%b want vld=%b data=%h frz=1",
                         k, out_vld, out_data, frozen, gen_vld(a), gen_data(a));
            end
        end
        step(1);
        n_tests++;
        if (out_vld !== 2'b00 || frozen !== 1'b1) begin
            n_fail++;
            $display("FAIL once_end: got vld=%b frz=%b want 00/1", out_vld, frozen);
        end
        step(3);
        n_tests++;
        if (out_vld !== 2'b00 || wr_ptr !== 4'd9) begin
            n_fail++;
            $display("FAIL once_no_replay: got vld=%b wp=%0d want 00/9", out_vld, wr_ptr);
        end
        mode = 2'b00;
        step(1);
    endtask

    task automatic test_loop_abort();
        logic [3:0] a;
        mode = 2'b10;
        step(2);
        for (int k = 0; k < 40; k++) begin
            step(1);
            a = 4'(9 + k);
            n_tests++;
            if ({out_vld, out_data} !== {gen_vld(a), gen_data(a)}) begin
                n_fail++;
                $display("FAIL loop_word[%0d]: got vld=%b data=%h want vld=%b data=%h",
                         k, out_vld, out_data, gen_vld(a), gen_data(a));
            end
        end
        mode = 2'b00;
        step(1);
        n_tests++;
        if (out_vld !== 2'b00 || frozen !== 1'b1) begin
            n_fail++;
            $display("FAIL abort: got vld=%b frz=%b want 00/1", out_vld, frozen);
        end
        step(1);
        n_tests++;
        if (out_vld !== 2'b00 || wr_ptr !== 4'd9) begin
            n_fail++;
            $display("FAIL abort_after: got vld=%b wp=%0d want 00/9", out_vld, wr_ptr);
        end
    endtask

    task automatic test_init();
        int busy;
        busy = 0;
        mon_data = 16'h3C3C; mon_vld = 2'b11; init_pattern = 8'hA5; mode = 2'b11;
        step(1);
        mode = 2'b00;
        for (int i = 0; i < 21; i++) begin
            if (init_busy === 1'b1) begin
                busy++;
                n_tests++;
                if (out_vld !== 2'b00) begin
                    n_fail++;
                    $display("FAIL init_out_vld[%0d]: got %b want 00", i, out_vld);
                end
            end
            if (i >= 2 && i <= 17) begin
                n_tests++;
                if (spy_vld !== 1'b1 || spy_data !== 8'hA5) begin
                    n_fail++;
                    $display("FAIL init_spy[a%0d]: got %b/%h want 1/a5", i - 2, spy_vld, spy_data);
                end
            end
            if (i == 16) begin
                n_tests++;
                if (wr_ptr !== 4'd0 || init_busy !== 1'b0 || frozen !== 1'b0) begin
                    n_fail++;
                    $display("FAIL init_done: got wp=%0d busy=%b frz=%b want 0/0/0", wr_ptr, init_busy, frozen);
                end
            end
            if (i >= 1 && i <= 16) begin
                spy_en = 1'b1; spy_ch = 1'(i); spy_addr = 4'(i - 1);
            end else begin
                spy_en = 1'b0;
            end
            step(1);
        end
        n_tests++;
        if (busy != 16) begin
            n_fail++;
            $display("FAIL init_busy_len: got %0d want 16", busy);
        end
        exp_wp = 4'd5;
    endtask

    task automatic test_corners();
        arm = 1'b1; trig = 1'b1; post_cnt = 4'd0;
        spy_en = 1'b1; spy_ch = 1'b0; spy_addr = exp_wp;
        step(1);
        arm = 1'b0; trig = 1'b0;
        n_tests++;
        if (frozen !== 1'b0 || trig_addr !== 4'd5 || wr_ptr !== 4'd6) begin
            n_fail++;
            $display("FAIL arm_trig_same: got frz=%b ta=%0d wp=%0d want 0/5/6", frozen, trig_addr, wr_ptr);
        end
        n_tests++;
        if (spy_vld !== 1'b1 || spy_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL spy_read_first: got %b/%h want 1/a5", spy_vld, spy_data);
        end
        trig = 1'b1;
        step(1);
        trig = 1'b0;
        n_tests++;
        if (frozen !== 1'b1 || trig_addr !== 4'd6 || wr_ptr !== 4'd7) begin
            n_fail++;
            $display("FAIL post_zero: got frz=%b ta=%0d wp=%0d want 1/6/7", frozen, trig_addr, wr_ptr);
        end
        n_tests++;
        if (spy_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL spy_after_write: got %h want 3c", spy_data);
        end
        spy_en = 1'b0;
        step(2);
        n_tests++;
        if (frozen !== 1'b1 || wr_ptr !== 4'd7) begin
            n_fail++;
            $display("FAIL post_zero_hold: got frz=%b wp=%0d want 1/7", frozen, wr_ptr);
        end
    endtask

    task automatic test_reset_in_play();
        mon_data = 16'h0000; mon_vld = 2'b00; mode = 2'b10;
        step(1);
        step(3);
        n_tests++;
        if ({out_vld, out_data} !== {2'b00, 16'hA5A5}) begin
            n_fail++;
            $display("FAIL play_init_word: got vld=%b data=%h want 00/a5a5", out_vld, out_data);
        end
        step(8);
        n_tests++;
        if ({out_vld, out_data} !== {2'b11, 16'h3C3C}) begin
            n_fail++;
            $display("FAIL play_cap_word: got vld=%b data=%h want 11/3c3c", out_vld, out_data);
        end
        rst_hs = 1'b1;
        #1;
        n_tests++;
        if ({out_vld, out_data, frozen, wr_ptr, trig_addr} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_in_play: got vld=%b data=%h frz=%b wp=%0d ta=%0d want all 0",
                     out_vld, out_data, frozen, wr_ptr, trig_addr);
        end
        mode = 2'b00;
        step(2);
        rst_hs = 1'b0;
        mon_data = 16'h5A5A; mon_vld = 2'b10;
        step(1);
        n_tests++;
        if ({out_vld, out_data} !== {2'b10, 16'h5A5A} || wr_ptr !== 4'd1 || frozen !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_capture: got vld=%b data=%h wp=%0d frz=%b want 10/5a5a/1/0",
                     out_vld, out_data, wr_ptr, frozen);
        end
    endtask

    initial begin
        exp_wp = 4'd0;
        test_reset();
        test_trigger();
        test_play_once();
        test_loop_abort();
        test_init();
        test_corners();
        test_reset_in_play();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
